led_blink_sequencer: RTL
========================

Name: led_blink_sequencer

Overview:
- Timing controller that sequences an LED through programmable on/off blink patterns.
- Built on an internal clock-divider tick, the same prescaling the existing divider block provides.
- Latches a pattern configuration on a start pulse and runs a fixed or infinite number of periods.
- Reports busy and done so top-level control logic can chain patterns or stop them.

Parameters:
- TICK_DIV, 4, clk cycles per timing tick (>=2); the prescaler counts 0..TICK_DIV-1.
- CNT_W, 8, width of the on/off duration fields, in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request to begin a pattern; ignored while busy=1.
- stop  in  1  single-cycle abort request.
- mode  in  1  0 = single blink (ON, OFF); 1 = double blink (ON, OFF, ON, OFF-long).
- on_ticks  in  CNT_W  ON duration in ticks; 0 is treated as 1.
- off_ticks  in  CNT_W  OFF duration in ticks; 0 is treated as 1. OFF-long is 2*off_ticks (CNT_W+1 bits internally).
- repeat_cnt  in  8  number of pattern periods; 0 means run forever.
- led  out  1  LED drive, registered.
- busy  out  1  high while a pattern is running.
- done  out  1  one-cycle pulse when a finite pattern completes.

Behaviour:
- Reset (asynchronous): state=IDLE, led=0, busy=0, done=0, prescaler=0, duration counter=0, repeat counter=0.
- Configuration: mode, on_ticks, off_ticks and repeat_cnt are sampled only on the accepted start edge. Input changes mid-pattern have no effect.
- FSM states: IDLE, ON1, OFF1, ON2, OFF2.
  - IDLE -> ON1 on start (when stop=0).
  - ON1 -> OFF1 after on_ticks ticks.
  - OFF1 -> ON2 if mode=1, after off_ticks ticks.
  - OFF1 -> end-of-period if mode=0, after off_ticks ticks.
  - ON2 -> OFF2 after on_ticks ticks.
  - OFF2 -> end-of-period after 2*off_ticks ticks.
- End-of-period:
  - If repeat_cnt=0, go to ON1.
  - Else decrement the remaining-period counter. If the result is nonzero go to ON1; otherwise go to IDLE and pulse done.
- Tick generation:
  - The prescaler restarts at 0 on every state entry.
  - A tick occurs when the prescaler reaches TICK_DIV-1.
  - Each state therefore lasts exactly duration*TICK_DIV clk cycles.
- led is 1 in ON1/ON2 and 0 in IDLE/OFF1/OFF2. It is registered from the next state, so led changes on the same edge as the state transition.
- Latency: start sampled at edge N gives busy=1 and led=1 from edge N+1.
- Completion:
  - done=1 for exactly one cycle, in the cycle busy first reads 0.
  - led=0 at that time.
- Stop:
  - stop at edge N gives state=IDLE, led=0, busy=0 from edge N+1.
  - No done pulse is produced.
  - stop in IDLE has no effect.
- Simultaneous events:
  - start and stop in the same cycle: stop wins and no pattern starts.
  - start in the same cycle that done is generated: start is accepted (busy is low in that cycle) and the next pattern begins at the following edge.
- Busy rules:
  - start while busy=1 is ignored and the running pattern is unaffected.
  - busy=1 in every non-IDLE state.
- Reset mid-pattern: immediately returns all outputs to their reset values, with no done pulse.
- Width: the duration counter is CNT_W+1 bits so that 2*off_ticks never wraps.

Test Plan:
- TICK_DIV=4, mode=0, on=2, off=3, repeat=2 -> led high 8 clk, low 12, high 8, low 12. busy high 40 clk. done pulses once, in the first cycle with busy=0.
- mode=1, on=1, off=1, repeat=1 -> led high 4, low 4, high 4, low 8. busy 20 clk. done pulses once.
- repeat=0, on=1, off=1 -> led toggles every 4 clk for 200 clk with no done. Assert stop mid-ON -> led=0 and busy=0 next edge, done stays 0.
- on_ticks=0, off_ticks=0, repeat=1, mode=0 -> treated as 1/1: led high 4, low 4, then done.
- start held high throughout a running pattern, plus start and stop together from IDLE -> the running pattern is unchanged, and busy stays 0 for the simultaneous case.
- Assert rst asynchronously mid-OFF2 -> led, busy and done all 0 immediately. A new start after reset release begins a fresh pattern with correct 4-clk tick alignment.

Source files
------------

// File: rtl/led_blink_sequencer.sv
// led_blink_sequencer
// Drives an LED through single or double blink patterns timed by a prescaled
// tick. A start pulse latches the configuration. The pattern then repeats a
// fixed number of periods, or forever when repeat_cnt is 0. A stop pulse
// aborts the pattern at any time.
module led_blink_sequencer #(
   parameter int TICK_DIV = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [CNT_W-1:0] on_ticks,
   input  logic [CNT_W-1:0] off_ticks,
   input  logic [7:0]       repeat_cnt,
   output logic             led,
   output logic             busy,
   output logic             done
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0]  PRESC_ONE = PW'(1);
   localparam logic [CNT_W:0] DUR_ONE   = (CNT_W+1)'(1);

   typedef enum logic [2:0] {IDLE, ON1, OFF1, ON2, OFF2} state_t;

   state_t           state;
   state_t           next_state;
   logic [PW-1:0]    presc;
   logic [CNT_W:0]   dur_cnt;
   logic [CNT_W:0]   cur_dur;
   logic             cfg_mode;
   logic             cfg_inf;
   logic [CNT_W-1:0] cfg_on;
   logic [CNT_W-1:0] cfg_off;
   logic [7:0]       rep_left;
   logic             tick;
   logic             phase_end;
   logic             accept;
   logic             period_end;
   logic             finish;
   logic             restart;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: phase lengths, end-of-period handling, and stop priority
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      period_end = 1'b0;
      finish     = 1'b0;
      case (state)
         OFF1:    cur_dur = {1'b0, cfg_off};
         OFF2:    cur_dur = {cfg_off, 1'b0};
         default: cur_dur = {1'b0, cfg_on};
      endcase
      tick      = (presc == PRESC_MAX);
      phase_end = tick && (dur_cnt == cur_dur - DUR_ONE);
      case (state)
         IDLE: begin
            if (start && !stop) begin
               next_state = ON1;
               accept     = 1'b1;
            end
         end
         ON1:  if (phase_end) next_state = OFF1;
         OFF1: begin
            if (phase_end) begin
               if (cfg_mode) next_state = ON2;
               else          period_end = 1'b1;
            end
         end
         ON2:  if (phase_end) next_state = OFF2;
         OFF2: if (phase_end) period_end = 1'b1;
         default: next_state = IDLE;
      endcase
      if (period_end) begin
         if (!cfg_inf && rep_left == 8'd1) begin
            next_state = IDLE;
            finish     = 1'b1;
         end else begin
            next_state = ON1;
         end
      end
      if (stop && state != IDLE) begin
         next_state = IDLE;
         finish     = 1'b0;
      end
      restart = (next_state != state);
   end

   // Prescaler and duration counter restart on every state entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc   <= '0;
         dur_cnt <= '0;
      end else if (restart || next_state == IDLE) begin
         presc   <= '0;
         dur_cnt <= '0;
      end else if (tick) begin
         presc   <= '0;
         dur_cnt <= dur_cnt + DUR_ONE;
      end else begin
         presc   <= presc + PRESC_ONE;
      end
   end

   // Configuration latch on accepted start. Zero durations become 1 here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_mode <= 1'b0;
         cfg_inf  <= 1'b0;
         cfg_on   <= '0;
         cfg_off  <= '0;
         rep_left <= '0;
      end else if (accept) begin
         cfg_mode <= mode;
         cfg_inf  <= (repeat_cnt == 8'd0);
         cfg_on   <= (on_ticks == '0) ? CNT_W'(1) : on_ticks;
         cfg_off  <= (off_ticks == '0) ? CNT_W'(1) : off_ticks;
         rep_left <= repeat_cnt;
      end else if (period_end && !stop && !cfg_inf) begin
         rep_left <= rep_left - 8'd1;
      end
   end

   // Outputs registered from next state, so they move with the transition
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led  <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         led  <= (next_state == ON1) || (next_state == ON2);
         busy <= (next_state != IDLE);
         done <= finish;
      end
   end

endmodule
